// File: rtl/alu_pkg.sv
// Types and decode helpers for the M-extension multiply/divide unit.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic is_div(muldiv_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(muldiv_op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic is_mul_high(muldiv_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  function automatic logic is_signed_rs1(muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_rs2(muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit; one request in flight.
// Multiply and divide share the 2*XLEN shift register and the iteration counter.
module muldiv_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned     CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   divisor;
  muldiv_op_e        op_q;
  logic              neg_q;
  logic              neg_r;
  logic              special;

  muldiv_op_e      op_in;
  logic            s1, s2, div_zero, div_ovf;
  logic [XLEN-1:0] mag1, mag2, special_res;

  always_comb begin
    op_in       = muldiv_op_e'(op);
    s1          = is_signed_rs1(op_in) && in1[XLEN-1];
    s2          = is_signed_rs2(op_in) && in2[XLEN-1];
    mag1        = s1 ? -in1 : in1;
    mag2        = s2 ? -in2 : in2;
    div_zero    = is_div(op_in) && (in2 == '0);
    div_ovf     = (op_in inside {OP_DIV, OP_REM}) && (in1 == MOST_NEG) && (in2 == '1);
    special_res = is_rem(op_in) ? (div_zero ? in1 : '0) : (div_zero ? '1 : in1);
  end

  logic [XLEN:0]     mul_sum, div_diff;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, iter_nxt, mul_prod;
  logic [XLEN-1:0]   quo, rem, final_res;

  // mul: {hi,lo} shifts right, adding the multiplicand into hi when lo[0] is set.
  // div: {rem,quo} shifts left, keeping the trial subtraction when it does not borrow.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, divisor} : '0);
    mul_nxt  = {mul_sum, acc[XLEN-1:1]};
    div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, divisor};
    div_nxt  = div_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    iter_nxt = (state == ST_DIV) ? div_nxt : mul_nxt;
    mul_prod = neg_q ? -mul_nxt : mul_nxt;
    quo      = neg_q ? -div_nxt[XLEN-1:0] : div_nxt[XLEN-1:0];
    rem      = neg_r ? -div_nxt[2*XLEN-1:XLEN] : div_nxt[2*XLEN-1:XLEN];
    if (special)
      final_res = acc[XLEN-1:0];
    else if (is_div(op_q))
      final_res = is_rem(op_q) ? rem : quo;
    else
      final_res = is_mul_high(op_q) ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];
  end

  assign in_ready = (state == ST_IDLE) && !flush;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      acc       <= '0;
      divisor   <= '0;
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      special   <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            op_q    <= op_in;
            divisor <= mag2;
            neg_q   <= s1 ^ s2;
            neg_r   <= s1;
            // Special divides take one pass through DIV with cnt=0 so the
            // result lands one edge after accept, like a 1-iteration op.
            if (div_zero || div_ovf) begin
              special <= 1'b1;
              acc     <= {{XLEN{1'b0}}, special_res};
              cnt     <= '0;
              state   <= ST_DIV;
            end else begin
              special <= 1'b0;
              acc     <= {{XLEN{1'b0}}, mag1};
              cnt     <= CNT_LAST;
              state   <= is_div(op_in) ? ST_DIV : ST_MUL;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          acc <= iter_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            cnt       <= '0;
            result    <= final_res;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
